// File: rtl/imem_fetch_ctrl_if.sv
// Fetch controller bus bundle: PC/control in, ROM port, decode handshake.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              misalign_err;

  modport slave (
    input  fetch_en, redirect_valid, redirect_pc,
    input  imem_data, out_ready,
    output imem_addr, out_valid, out_inst, out_pc,
    output misalign_err
  );

  modport master (
    output fetch_en, redirect_valid, redirect_pc,
    output imem_data, out_ready,
    input  imem_addr, out_valid, out_inst, out_pc,
    input  misalign_err
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer with prefetch queue and redirect flush.
// FETCH_MISALIGN_CHECK_EN: halt with sticky error on misaligned redirect.
module imem_fetch_ctrl #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_fetch_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_inst [DEPTH];
  logic [ADDR_W-1:0] r_ipc  [DEPTH];

  logic              w_pop;
  logic              w_push;
  logic              w_redir;
  logic              w_bad;
  logic [ADDR_W-1:0] w_tgt;

  assign w_pop   = (r_cnt != '0) & bus.out_ready;
  assign w_redir = bus.redirect_valid & (r_state != HALT);
  assign w_push  = (r_state == RUN) & ~bus.redirect_valid
                 & ((r_cnt < CW'(DEPTH)) | w_pop);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_err;

  assign w_bad = w_redir & (bus.redirect_pc[1:0] != 2'b00);
  assign w_tgt = bus.redirect_pc;
  assign bus.misalign_err = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_bad = 1'b0;
  assign w_tgt = bus.redirect_pc & ~ADDR_W'(3);
  assign bus.misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_inst[i] <= '0;
        r_ipc[i]  <= '0;
      end
    end else begin
      if (w_bad) begin
        r_state <= HALT;
      end else if (r_state == IDLE && bus.fetch_en) begin
        r_state <= RUN;
      end else if (r_state == RUN && !bus.fetch_en) begin
        r_state <= IDLE;
      end

      // Redirect wins: flush, and a same-cycle pop is discarded.
      if (w_redir) begin
        r_cnt  <= '0;
        r_head <= '0;
        r_tail <= '0;
        if (!w_bad) r_pc <= w_tgt;
      end else begin
        if (w_push) begin
          r_inst[r_tail] <= bus.imem_data;
          r_ipc[r_tail]  <= r_pc;
          r_tail         <= r_tail + 1'b1;
          r_pc           <= r_pc + ADDR_W'(4);
        end
        if (w_pop) r_head <= r_head + 1'b1;
        if (w_push && !w_pop) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (w_pop && !w_push) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = (r_cnt != '0);
  assign bus.out_inst  = r_inst[r_head];
  assign bus.out_pc    = r_ipc[r_head];
endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the instruction memory. It owns the program counter, drives the 10-bit byte address into the combinational instruction ROM, and captures each returned 32-bit word together with its PC into a small prefetch queue. The queue presents instructions to decode through a valid/ready handshake. It sits between the PC logic and the decode stage, and absorbs branch/jump redirects by flushing the queue.

## Interface
- ADDR_W, 10, instruction-memory byte-address width
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- DEPTH, 2, prefetch queue entries (power of two, ≥2)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  1 = fetch, 0 = stop issuing new fetches
- redirect_valid  in  1  one-cycle pulse: load new PC, flush queue
- redirect_pc  in  ADDR_W  redirect target byte address
- imem_addr  out  ADDR_W  address to instruction memory (= PC register)
- imem_data  in  DATA_W  instruction word at imem_addr, same cycle
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_inst  out  DATA_W  head instruction
- out_pc  out  ADDR_W  head instruction address
- misalign_err  out  1  sticky misaligned-redirect flag

## Operation
- States: IDLE (reset state), RUN, HALT.
  - IDLE→RUN when fetch_en=1.
  - RUN→IDLE when fetch_en=0.
  - RUN or IDLE→HALT on a misaligned redirect (macro only).
  - HALT exits only through reset.
- pop = out_valid & out_ready.
- push = (state==RUN) & ~redirect_valid & (count<DEPTH | pop).
  - On push: the entry {imem_data, pc} is written at the tail, and pc ← pc+4.
- PC arithmetic is modulo 2^ADDR_W. For ADDR_W=10, 0x3FC+4 wraps to 0x000 with no flag.
- Redirect (any state except HALT) has priority over push and pop in the same cycle:
  - queue flushed (count←0)
  - pc ← redirect_pc
  - a pop in that cycle is not counted as accepted
- With push and pop in the same cycle on a full queue, count is unchanged and the push succeeds.
- IDLE: no pushes; queued entries still drain through the handshake.
- Queue is a circular buffer with head/tail pointers and a count of width log2(DEPTH)+1.
  - out_inst/out_pc are the head entry.
  - out_valid = (count≠0).
- imem_addr is always the pc register. The low two bits are zero whenever pc is aligned.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - pc=RESET_PC, imem_addr=RESET_PC
  - count=0, out_valid=0, out_inst=0, out_pc=0
  - misalign_err=0, state=IDLE
- Fetch latency:
  - fetch_en rising at edge N → state RUN after edge N.
  - First push at edge N+1 → out_valid=1 after edge N+1.
- Redirect asserted before edge R:
  - After R: out_valid=0 and imem_addr=redirect_pc.
  - Target instruction is pushed at R+1 and presented after R+1.
- Throughput: one instruction per cycle while out_ready=1 and fetch_en=1.
- Backpressure: with out_ready=0, the queue fills after DEPTH pushes. pc then holds, and out_inst/out_pc stay stable until accepted.
- Reset asserted mid-operation discards all queue contents immediately. A redirect pulse during reset is ignored.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]≠0 sets misalign_err=1 (sticky) at that edge and flushes the queue.
  - pc is not loaded; state→HALT, so no further pushes occur.
- Undefined:
  - redirect_pc[1:0] is forced to 00 when loaded.
  - misalign_err is tied to 0 and HALT is unreachable.

## Test plan
- Reset then fetch_en=1, out_ready=1, ROM word k = 0x1000_0000+k → out_inst sequence 0x1000_0000, 0x1000_0001, … with out_pc 0x000, 0x004, 0x008…; first out_valid one cycle after RUN entry.
- out_ready=0 for 5 cycles after start → count saturates at 2, imem_addr holds 0x008, out_pc stays 0x000; release → 0x000, 0x004, 0x008 in consecutive cycles with no duplicates or gaps.
- Redirect to 0x040 while queue full and out_ready=1 → next cycle out_valid=0, imem_addr=0x040; following cycle out_pc=0x040; neither 0x004 nor 0x008 is ever presented.
- Run from RESET_PC=0x3F8 → out_pc sequence 0x3F8, 0x3FC, 0x000, 0x004.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x042 → misalign_err=1, out_valid=0, imem_addr unchanged; fetching stays stopped until rst_n pulse. Without the macro: the same redirect fetches from 0x040.
- rst_n low for one cycle mid-stream with two entries queued → out_valid=0 and imem_addr=RESET_PC immediately; fetching resumes from RESET_PC after release while fetch_en=1.
